object2_renderer: RTL and testbench

Reads pixels from the object2 sprite ROM (row/col address in, 12-bit color out, one registered address stage) and presents them on the VGA pixel pipeline. It compares the current scan position against a double-buffered object position and drives the ROM address. It aligns the ROM latency and outputs a registered color plus an opaque flag for the frame compositor. New positions arrive through a valid/ready handshake and take effect only at frame boundaries, so the object never tears mid-frame.

---
 rtl/object2_renderer.sv | 97 +++++++++
 tb/tb_object2_renderer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/object2_renderer.sv
// Sprite renderer for object2: hit test against a frame-synchronous position,
// ROM addressing, and a 2-cycle aligned color/opaque output for the compositor.
module object2_renderer #(
  parameter int               ROW_BITS  = 1,
  parameter int               COL_BITS  = 1,
  parameter int               COLOR_W   = 12,
  parameter logic [COLOR_W-1:0] KEY_COLOR = 12'h000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [9:0]          x,
  input  logic [9:0]          y,
  input  logic                video_on,
  input  logic                frame_tick,
  input  logic                obj_enable,
  input  logic [9:0]          pos_x_in,
  input  logic [9:0]          pos_y_in,
  input  logic                pos_valid,
  output logic                pos_ready,
  output logic [ROW_BITS-1:0] rom_row,
  output logic [COL_BITS-1:0] rom_col,
  input  logic [COLOR_W-1:0]  rom_color,
  output logic                pixel_on,
  output logic [COLOR_W-1:0]  pixel_color
);

  localparam logic [10:0] W_EXT = 11'(1 << COL_BITS);
  localparam logic [10:0] H_EXT = 11'(1 << ROW_BITS);

  logic [9:0] active_x, active_y;
  logic [9:0] pending_x, pending_y;
  logic       pending_full;
  logic       hit_d1;

  logic        accept;
  logic        pending_full_next;
  logic [10:0] x_ext, y_ext, x_end, y_end;
  logic [9:0]  dx, dy;
  logic        hit;
  logic        on_next;

  assign accept = pos_valid && pos_ready;

  // An accept only happens with pending empty, so it never races a swap.
  always_comb begin
    pending_full_next = pending_full;
    if (frame_tick && pending_full) pending_full_next = 1'b0;
    if (accept)                     pending_full_next = 1'b1;
  end

  // Extended to 11 bits so objects near the right/bottom edge clip instead of wrapping.
  assign x_ext = {1'b0, x};
  assign y_ext = {1'b0, y};
  assign x_end = {1'b0, active_x} + W_EXT;
  assign y_end = {1'b0, active_y} + H_EXT;

  assign hit = video_on && obj_enable &&
               (x >= active_x) && (x_ext < x_end) &&
               (y >= active_y) && (y_ext < y_end);

  assign dx = x - active_x;
  assign dy = y - active_y;

  assign rom_col = hit ? dx[COL_BITS-1:0] : '0;
  assign rom_row = hit ? dy[ROW_BITS-1:0] : '0;

  assign on_next = hit_d1 && (rom_color != KEY_COLOR);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      active_x     <= '0;
      active_y     <= '0;
      pending_x    <= '0;
      pending_y    <= '0;
      pending_full <= 1'b0;
      pos_ready    <= 1'b0;
      hit_d1       <= 1'b0;
      pixel_on     <= 1'b0;
      pixel_color  <= KEY_COLOR;
    end else begin
      if (frame_tick && pending_full) begin
        active_x <= pending_x;
        active_y <= pending_y;
      end
      if (accept) begin
        pending_x <= pos_x_in;
        pending_y <= pos_y_in;
      end
      pending_full <= pending_full_next;
      pos_ready    <= !pending_full_next;
      hit_d1       <= hit;
      pixel_on     <= on_next;
      pixel_color  <= on_next ? rom_color : KEY_COLOR;
    end
  end

endmodule

// File: tb/tb_object2_renderer.sv
// Directed bench for object2_renderer with a registered 2x2 sprite ROM model.
module tb_object2_renderer;

  logic        clk;
  logic        reset_n;
  logic [9:0]  x, y;
  logic        video_on;
  logic        frame_tick;
  logic        obj_enable;
  logic [9:0]  pos_x_in, pos_y_in;
  logic        pos_valid;
  logic        pos_ready;
  logic [0:0]  rom_row;
  logic [0:0]  rom_col;
  logic [11:0] rom_color;
  logic        pixel_on;
  logic [11:0] pixel_color;

  logic        rom_force_key;
  int          checks;
  int          errors;

  object2_renderer dut (
    .clk(clk), .reset_n(reset_n), .x(x), .y(y), .video_on(video_on),
    .frame_tick(frame_tick), .obj_enable(obj_enable),
    .pos_x_in(pos_x_in), .pos_y_in(pos_y_in), .pos_valid(pos_valid),
    .pos_ready(pos_ready), .rom_row(rom_row), .rom_col(rom_col),
    .rom_color(rom_color), .pixel_on(pixel_on), .pixel_color(pixel_color)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sprite ROM: row 0 is white, row 1 has two distinct colors.
  function automatic logic [11:0] rom_data(input logic r, input logic c);
    case ({r, c})
      2'b00:   rom_data = 12'hFFF;
      2'b01:   rom_data = 12'hFFF;
      2'b10:   rom_data = 12'h0A5;
      default: rom_data = 12'h5A0;
    endcase
  endfunction

  always_ff @(posedge clk)
    rom_color <= rom_force_key ? 12'h000 : rom_data(rom_row, rom_col);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input string name, input logic [9:0] px, input logic [9:0] py,
                       input logic vo, input logic en, input logic e_row, input logic e_col,
                       input logic e_on, input logic [11:0] e_color);
    x = px; y = py; video_on = vo; obj_enable = en;
    #1;
    checks++;
    if (rom_row !== e_row || rom_col !== e_col) begin
      errors++;
      $display("FAIL %s addr: got row=%0d col=%0d expected row=%0d col=%0d",
               name, rom_row, rom_col, e_row, e_col);
    end
    @(posedge clk);
    #1;
    video_on = 1'b0;
    tick();
    checks++;
    if (pixel_on !== e_on || pixel_color !== e_color) begin
      errors++;
      $display("FAIL %s pixel: got on=%0b color=%h expected on=%0b color=%h",
               name, pixel_on, pixel_color, e_on, e_color);
    end
    obj_enable = 1'b1;
  endtask

  task automatic set_pos(input logic [9:0] px, input logic [9:0] py);
    int n;
    n = 0;
    while (pos_ready !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (pos_ready !== 1'b1) begin
      errors++;
      $display("FAIL set_pos ready timeout: got pos_ready=%b expected 1", pos_ready);
    end
    pos_x_in = px; pos_y_in = py; pos_valid = 1'b1;
    tick();
    pos_valid = 1'b0;
    checks++;
    if (pos_ready !== 1'b0) begin
      errors++;
      $display("FAIL set_pos pending_full: got pos_ready=%b expected 0", pos_ready);
    end
  endtask

  task automatic do_frame_tick();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; pos_valid = 1'b1; pos_x_in = 10'd5; pos_y_in = 10'd5;
    repeat (3) tick();
    checks++;
    if (pos_ready !== 1'b0 || pixel_on !== 1'b0 || pixel_color !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: got ready=%b on=%b color=%h expected 0 0 000",
               pos_ready, pixel_on, pixel_color);
    end
    reset_n = 1'b1; pos_valid = 1'b0;
    #1;
    checks++;
    if (pos_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 0", pos_ready);
    end
    tick();
    checks++;
    if (pos_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_rise: got %b expected 1", pos_ready);
    end
    probe("reset_active_origin", 10'd0, 10'd0, 1, 1, 0, 0, 1, 12'hFFF);
  endtask

  task automatic test_basic_draw();
    set_pos(10'd100, 10'd50);
    do_frame_tick();
    checks++;
    if (pos_ready !== 1'b1) begin
      errors++;
      $display("FAIL swap_ready: got %b expected 1", pos_ready);
    end
    probe("draw_x99",   10'd99,  10'd50, 1, 1, 0, 0, 0, 12'h000);
    probe("draw_x100",  10'd100, 10'd50, 1, 1, 0, 0, 1, 12'hFFF);
    probe("draw_x101",  10'd101, 10'd50, 1, 1, 0, 1, 1, 12'hFFF);
    probe("draw_x102",  10'd102, 10'd50, 1, 1, 0, 0, 0, 12'h000);
    probe("draw_row1a", 10'd100, 10'd51, 1, 1, 1, 0, 1, 12'h0A5);
    probe("draw_row1b", 10'd101, 10'd51, 1, 1, 1, 1, 1, 12'h5A0);
    probe("draw_y52",   10'd100, 10'd52, 1, 1, 0, 0, 0, 12'h000);
    probe("draw_y49",   10'd100, 10'd49, 1, 1, 0, 0, 0, 12'h000);
  endtask

  task automatic test_deferred_update();
    set_pos(10'd200, 10'd60);
    probe("defer_old_drawn", 10'd100, 10'd50, 1, 1, 0, 0, 1, 12'hFFF);
    probe("defer_new_hidden", 10'd200, 10'd60, 1, 1, 0, 0, 0, 12'h000);
  endtask

  task automatic test_back_to_back();
    pos_x_in = 10'd300; pos_y_in = 10'd70; pos_valid = 1'b1;
    tick();
    tick();
    checks++;
    if (pos_ready !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_ready: got %b expected 0", pos_ready);
    end
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    checks++;
    if (pos_ready !== 1'b1) begin
      errors++;
      $display("FAIL held_ready_after_swap: got %b expected 1", pos_ready);
    end
    tick();
    pos_valid = 1'b0;
    checks++;
    if (pos_ready !== 1'b0) begin
      errors++;
      $display("FAIL held_accepted: got pos_ready=%b expected 0", pos_ready);
    end
    probe("swap_new_drawn",  10'd200, 10'd60, 1, 1, 0, 0, 1, 12'hFFF);
    probe("swap_old_gone",   10'd100, 10'd50, 1, 1, 0, 0, 0, 12'h000);
    do_frame_tick();
    probe("held_applied",    10'd301, 10'd70, 1, 1, 0, 1, 1, 12'hFFF);
    probe("held_prev_gone",  10'd200, 10'd60, 1, 1, 0, 0, 0, 12'h000);
    // Accept coinciding with frame_tick on an empty pending slot.
    pos_x_in = 10'd400; pos_y_in = 10'd80; pos_valid = 1'b1; frame_tick = 1'b1;
    tick();
    pos_valid = 1'b0; frame_tick = 1'b0;
    checks++;
    if (pos_ready !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_pending: got pos_ready=%b expected 0", pos_ready);
    end
    probe("same_cycle_old",  10'd300, 10'd70, 1, 1, 0, 0, 1, 12'hFFF);
    probe("same_cycle_new0", 10'd400, 10'd80, 1, 1, 0, 0, 0, 12'h000);
    do_frame_tick();
    probe("same_cycle_new1", 10'd400, 10'd81, 1, 1, 1, 0, 1, 12'h0A5);
  endtask

  task automatic test_clip_transparency();
    set_pos(10'd639, 10'd479);
    do_frame_tick();
    probe("clip_corner", 10'd639, 10'd479, 1, 1, 0, 0, 1, 12'hFFF);
    probe("clip_x0",     10'd0,   10'd479, 1, 1, 0, 0, 0, 12'h000);
    probe("clip_y0",     10'd639, 10'd0,   1, 1, 0, 0, 0, 12'h000);
    probe("clip_origin", 10'd0,   10'd0,   1, 1, 0, 0, 0, 12'h000);
    probe("clip_x638",   10'd638, 10'd479, 1, 1, 0, 0, 0, 12'h000);
    rom_force_key = 1'b1;
    probe("transparent", 10'd639, 10'd479, 1, 1, 0, 0, 0, 12'h000);
    rom_force_key = 1'b0;
  endtask

  task automatic test_gating_reset();
    probe("gate_video_off", 10'd639, 10'd479, 0, 1, 0, 0, 0, 12'h000);
    probe("gate_obj_off",   10'd639, 10'd479, 1, 0, 0, 0, 0, 12'h000);
    set_pos(10'd500, 10'd100);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (pos_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ready: got %b expected 1", pos_ready);
    end
    do_frame_tick();
    probe("midreset_origin", 10'd1,   10'd1,   1, 1, 1, 1, 1, 12'h5A0);
    probe("midreset_discard", 10'd500, 10'd100, 1, 1, 0, 0, 0, 12'h000);
  endtask

  initial begin
    checks = 0; errors = 0;
    reset_n = 1'b0; x = '0; y = '0; video_on = 1'b0; frame_tick = 1'b0;
    obj_enable = 1'b1; pos_x_in = '0; pos_y_in = '0; pos_valid = 1'b0;
    rom_force_key = 1'b0;
    #1;
    test_reset();
    test_basic_draw();
    test_deferred_update();
    test_back_to_back();
    test_clip_transparency();
    test_gating_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
